// File: rtl/bus_load_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_load_regs_pkg
// Brief   : Shared sizes, MDR read-controller state encoding and helpers.
// Revision: 1.0 - initial release
// ============================================================================
package bus_load_regs_pkg;

  localparam int NUM_REGS    = 16;
  localparam int DATA_W      = 32;
  localparam int NUM_ENABLES = NUM_REGS + 7;
  localparam int TMO_W       = 8;
  localparam logic [TMO_W-1:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    MDR_IDLE = 2'd0,
    MDR_WAIT = 2'd1,
    MDR_DONE = 2'd2
  } mdr_state_e;

  // True when two or more load enables are active together.
  function automatic logic multi_hot(input logic [NUM_ENABLES-1:0] en);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_ENABLES; i++) begin
      if (en[i]) n++;
    end
    return (n >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_load_regs_mdr_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdr_read_ctrl
// Brief   : MDR register with memory-read FSM and timeout counter.
// Revision: 1.0 - initial release
// ============================================================================
module mdr_read_ctrl
  import bus_load_regs_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              i_read,
  input  logic              i_mem_ready,
  input  logic              i_mdr_in,
  input  logic [DATA_W-1:0] i_mdatain,
  input  logic [DATA_W-1:0] i_bus,
  output logic [DATA_W-1:0] o_mdr,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic              o_mdr_in_reject
);

  mdr_state_e        state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              err_q, err_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mdr_d           = mdr_q;
    err_d           = err_q;
    o_mdr_in_reject = 1'b0;
    case (state_q)
      MDR_IDLE: begin
        if (i_read) begin
          state_d         = MDR_WAIT;
          cnt_d           = '0;
          o_mdr_in_reject = i_mdr_in;
        end else if (i_mdr_in) begin
          mdr_d = i_bus;
        end
      end
      MDR_WAIT: begin
        o_mdr_in_reject = i_mdr_in;
        if (i_mem_ready) begin
          mdr_d   = i_mdatain;
          state_d = MDR_DONE;
        end else if (cnt_q == TIMEOUT_LIMIT) begin
          err_d   = 1'b1;
          state_d = MDR_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      MDR_DONE: begin
        o_mdr_in_reject = i_mdr_in;
        state_d         = MDR_IDLE;
      end
      default: state_d = MDR_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= MDR_IDLE;
      cnt_q   <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  assign o_mdr         = mdr_q;
  assign o_busy        = (state_q != MDR_IDLE);
  assign o_err_timeout = err_q;

endmodule
`default_nettype wire

// File: rtl/bus_load_regs.sv
`default_nettype none
// ============================================================================
// Module  : bus_load_regs
// Brief   : Bus-loaded general and special registers with MDR memory read.
// Revision: 1.0 - initial release
// ============================================================================
module bus_load_regs
  import bus_load_regs_pkg::*;
(
  input  logic                       clock,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          BusMuxOut,
  input  logic [NUM_REGS-1:0]        Rin,
  input  logic                       HIin,
  input  logic                       LOin,
  input  logic                       Yin,
  input  logic                       PCin,
  input  logic                       MARin,
  input  logic                       MDRin,
  input  logic                       IRin,
  input  logic                       IncPC,
  input  logic                       Read,
  input  logic [DATA_W-1:0]          Mdatain,
  input  logic                       mem_ready,
  output logic [NUM_REGS*DATA_W-1:0] Rq,
  output logic [DATA_W-1:0]          HIq,
  output logic [DATA_W-1:0]          LOq,
  output logic [DATA_W-1:0]          Yq,
  output logic [DATA_W-1:0]          PCq,
  output logic [DATA_W-1:0]          MARq,
  output logic [DATA_W-1:0]          MDRq,
  output logic [DATA_W-1:0]          IRq,
  output logic                       mdr_busy,
  output logic                       err_multi_load,
  output logic                       err_mem_timeout
);

  logic [NUM_REGS*DATA_W-1:0] rq_q, rq_d;
  logic [DATA_W-1:0]          hi_q, hi_d, lo_q, lo_d, y_q, y_d;
  logic [DATA_W-1:0]          pc_q, pc_d, mar_q, mar_d, ir_q, ir_d;
  logic                       err_multi_q, err_multi_d;
  logic                       w_mdr_in_reject;

  always_comb begin
    rq_d = rq_q;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (Rin[n]) rq_d[n*DATA_W +: DATA_W] = BusMuxOut;
    end
    hi_d  = HIin  ? BusMuxOut : hi_q;
    lo_d  = LOin  ? BusMuxOut : lo_q;
    y_d   = Yin   ? BusMuxOut : y_q;
    mar_d = MARin ? BusMuxOut : mar_q;
    ir_d  = IRin  ? BusMuxOut : ir_q;
    // A bus load of PC takes priority over the increment.
    if (PCin)       pc_d = BusMuxOut;
    else if (IncPC) pc_d = pc_q + 32'd1;
    else            pc_d = pc_q;
    err_multi_d = err_multi_q
                | multi_hot({Rin, HIin, LOin, Yin, PCin, MARin, MDRin, IRin})
                | (PCin & IncPC)
                | w_mdr_in_reject;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      rq_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      y_q         <= '0;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      err_multi_q <= 1'b0;
    end else begin
      rq_q        <= rq_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      y_q         <= y_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      err_multi_q <= err_multi_d;
    end
  end

  mdr_read_ctrl u_mdr (
    .clock           (clock),
    .clear           (clear),
    .i_read          (Read),
    .i_mem_ready     (mem_ready),
    .i_mdr_in        (MDRin),
    .i_mdatain       (Mdatain),
    .i_bus           (BusMuxOut),
    .o_mdr           (MDRq),
    .o_busy          (mdr_busy),
    .o_err_timeout   (err_mem_timeout),
    .o_mdr_in_reject (w_mdr_in_reject)
  );

  assign Rq             = rq_q;
  assign HIq            = hi_q;
  assign LOq            = lo_q;
  assign Yq             = y_q;
  assign PCq            = pc_q;
  assign MARq           = mar_q;
  assign IRq            = ir_q;
  assign err_multi_load = err_multi_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_load_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_load_regs
// Brief   : Directed bench for bus_load_regs with a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_load_regs;

  logic         clock = 1'b0;
  logic         clear;
  logic [31:0]  BusMuxOut, Mdatain;
  logic [15:0]  Rin;
  logic         HIin, LOin, Yin, PCin, MARin, MDRin, IRin, IncPC, Read, mem_ready;
  logic [511:0] Rq;
  logic [31:0]  HIq, LOq, Yq, PCq, MARq, MDRq, IRq;
  logic         mdr_busy, err_multi_load, err_mem_timeout;

  bus_load_regs dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .Rin(Rin),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .PCin(PCin), .MARin(MARin),
    .MDRin(MDRin), .IRin(IRin), .IncPC(IncPC), .Read(Read),
    .Mdatain(Mdatain), .mem_ready(mem_ready), .Rq(Rq), .HIq(HIq),
    .LOq(LOq), .Yq(Yq), .PCq(PCq), .MARq(MARq), .MDRq(MDRq), .IRq(IRq),
    .mdr_busy(mdr_busy), .err_multi_load(err_multi_load),
    .err_mem_timeout(err_mem_timeout)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: register file as an array, read outstanding tracked as
  // a count of cycles spent waiting plus a one-cycle completion flag.
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_y, m_pc, m_mar, m_mdr, m_ir;
  bit          m_errm, m_errt, m_fin;
  int          m_wait = -1;

  function automatic logic [511:0] m_rq();
    logic [511:0] v;
    for (int n = 0; n < 16; n++) v[n*32 +: 32] = m_r[n];
    return v;
  endfunction

  always @(posedge clock) begin : p_model
    if (clear) begin
      for (int n = 0; n < 16; n++) m_r[n] <= '0;
      m_hi <= '0; m_lo <= '0; m_y <= '0; m_pc <= '0;
      m_mar <= '0; m_mdr <= '0; m_ir <= '0;
      m_errm <= 1'b0; m_errt <= 1'b0; m_fin <= 1'b0; m_wait <= -1;
    end else begin
      if ($countones({Rin, HIin, LOin, Yin, PCin, MARin, MDRin, IRin}) >= 2 ||
          (PCin && IncPC)) m_errm <= 1'b1;
      for (int n = 0; n < 16; n++) if (Rin[n]) m_r[n] <= BusMuxOut;
      if (HIin)  m_hi  <= BusMuxOut;
      if (LOin)  m_lo  <= BusMuxOut;
      if (Yin)   m_y   <= BusMuxOut;
      if (MARin) m_mar <= BusMuxOut;
      if (IRin)  m_ir  <= BusMuxOut;
      if (PCin)       m_pc <= BusMuxOut;
      else if (IncPC) m_pc <= m_pc + 32'd1;
      if (m_fin) begin
        m_fin <= 1'b0;
        if (MDRin) m_errm <= 1'b1;
      end else if (m_wait >= 0) begin
        if (MDRin) m_errm <= 1'b1;
        if (mem_ready) begin
          m_mdr <= Mdatain; m_fin <= 1'b1; m_wait <= -1;
        end else if (m_wait == 255) begin
          m_errt <= 1'b1; m_wait <= -1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (Read) begin
        m_wait <= 0;
        if (MDRin) m_errm <= 1'b1;
      end else if (MDRin) begin
        m_mdr <= BusMuxOut;
      end
    end
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin : p_compare
    if (chk_en) begin
      check("rq",    Rq,   m_rq());
      check("hi",    HIq,  m_hi);
      check("lo",    LOq,  m_lo);
      check("y",     Yq,   m_y);
      check("pc",    PCq,  m_pc);
      check("mar",   MARq, m_mar);
      check("mdr",   MDRq, m_mdr);
      check("ir",    IRq,  m_ir);
      check("busy",  {511'd0, mdr_busy}, {511'd0, (m_wait >= 0) || m_fin});
      check("err_m", {511'd0, err_multi_load},  {511'd0, m_errm});
      check("err_t", {511'd0, err_mem_timeout}, {511'd0, m_errt});
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_in();
    clear = 1'b0; Rin = '0; HIin = 0; LOin = 0; Yin = 0; PCin = 0; MARin = 0;
    MDRin = 0; IRin = 0; IncPC = 0; Read = 0; mem_ready = 0;
  endtask

  int busy_n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in(); BusMuxOut = '0; Mdatain = '0;
    clear = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_rq",   Rq,   '0);
    check("rst_pc",   PCq,  '0);
    check("rst_busy", {511'd0, mdr_busy}, '0);
    check("rst_errm", {511'd0, err_multi_load}, '0);
    idle_in();

    // Single general-register load
    BusMuxOut = 32'h12345678; Rin = 16'h0020; tick(); idle_in(); tick();
    check("r5_load", Rq[191:160], 32'h12345678);
    check("r5_only", Rq, {320'd0, 32'h12345678, 160'd0});
    check("r5_errm", {511'd0, err_multi_load}, '0);

    // Boundary registers and special registers one at a time
    BusMuxOut = 32'h0000_00A0; Rin = 16'h0001; tick();
    idle_in(); BusMuxOut = 32'hF000_000F; Rin = 16'h8000; tick();
    idle_in(); BusMuxOut = 32'h1111_1111; HIin = 1; tick();
    idle_in(); BusMuxOut = 32'h2222_2222; LOin = 1; tick();
    idle_in(); BusMuxOut = 32'h3333_3333; MARin = 1; tick();
    idle_in(); BusMuxOut = 32'h4444_4444; IRin = 1; tick();
    idle_in(); BusMuxOut = 32'hFFFF_FFFF; tick(); tick();
    check("r15_load", Rq[511:480], 32'hF000000F);
    check("hi_load",  HIq, 32'h11111111);
    check("ir_load",  IRq, 32'h44444444);

    // Two enables together
    BusMuxOut = 32'hA5A5A5A5; Rin = 16'h0002; Yin = 1; tick(); idle_in(); tick();
    check("ml_r1",   Rq[63:32], 32'hA5A5A5A5);
    check("ml_y",    Yq, 32'hA5A5A5A5);
    check("ml_errm", {511'd0, err_multi_load}, 512'd1);
    tick(); tick();
    check("ml_sticky", {511'd0, err_multi_load}, 512'd1);
    clear = 1; tick(); idle_in(); tick();
    check("ml_clr", {511'd0, err_multi_load}, '0);

    // PC wrap then PCin/IncPC conflict
    BusMuxOut = 32'hFFFFFFFF; PCin = 1; tick(); idle_in();
    IncPC = 1; tick(); idle_in(); tick();
    check("pc_wrap", PCq, 32'h0);
    BusMuxOut = 32'h40; PCin = 1; IncPC = 1; tick(); idle_in(); tick();
    check("pc_win",  PCq, 32'h40);
    check("pc_errm", {511'd0, err_multi_load}, 512'd1);
    clear = 1; tick(); idle_in();

    // MDR bus load in idle
    BusMuxOut = 32'h0BADF00D; MDRin = 1; tick(); idle_in(); tick();
    check("mdr_bus", MDRq, 32'h0BADF00D);

    // Memory read, data on the third waiting cycle; a Read during the wait is ignored
    busy_n = 0;
    Read = 1; tick(); Read = 0; busy_n += int'(mdr_busy);
    tick(); busy_n += int'(mdr_busy); Read = 1;
    tick(); busy_n += int'(mdr_busy); Read = 0; mem_ready = 1; Mdatain = 32'hDEADBEEF;
    tick(); busy_n += int'(mdr_busy); mem_ready = 0;
    check("rd_data", MDRq, 32'hDEADBEEF);
    tick(); busy_n += int'(mdr_busy);
    tick(); busy_n += int'(mdr_busy);
    check("rd_busy_cycles", busy_n, 4);

    // mem_ready while idle must not disturb MDR
    mem_ready = 1; Mdatain = 32'h55555555; tick(); mem_ready = 0; tick();
    check("rdy_idle", MDRq, 32'hDEADBEEF);

    // Timeout
    busy_n = 0;
    Read = 1; tick(); Read = 0;
    for (int k = 0; k < 300; k++) begin
      busy_n += int'(mdr_busy);
      tick();
    end
    check("tmo_cycles", busy_n, 256);
    check("tmo_err",    {511'd0, err_mem_timeout}, 512'd1);
    check("tmo_mdr",    MDRq, 32'hDEADBEEF);
    check("tmo_idle",   {511'd0, mdr_busy}, '0);
    mem_ready = 1; Mdatain = 32'h77777777; tick(); mem_ready = 0; tick();
    check("tmo_late_rdy", MDRq, 32'hDEADBEEF);

    // Clear in the middle of a read
    BusMuxOut = 32'h77; Rin = 16'hFFFF; tick(); idle_in();
    Read = 1; tick(); Read = 0; tick();
    clear = 1; tick(); clear = 0;
    mem_ready = 1; Mdatain = 32'hCAFEF00D; tick(); mem_ready = 0; tick();
    check("clr_mdr",  MDRq, '0);
    check("clr_busy", {511'd0, mdr_busy}, '0);
    check("clr_rq",   Rq, '0);
    check("clr_pc",   PCq, '0);
    check("clr_errs", {510'd0, err_multi_load, err_mem_timeout}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
